// File: rtl/sub_pkg.sv
// Shared types and default widths for the serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SUB_NUM_BITS   = 16;
  localparam int SUB_DIGIT_BITS = 4;

endpackage

// File: rtl/adder_nbit.sv
// N-bit ripple-carry adder; used here as the per-digit datapath of the subtractor.
module adder_nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         carry_out
);

  logic [N:0] c;

  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = carry_in;
    for (int i = 0; i < N; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign carry_out = c[N];

endmodule

// File: rtl/serial_subtractor_16bit.sv
// Digit-serial two's-complement subtractor: difference = a - b, computed as
// a + ~b + 1 one digit per cycle through adder_nbit.
module serial_subtractor_16bit
  import sub_pkg::*;
#(
  parameter int NUM_BITS   = SUB_NUM_BITS,
  parameter int DIGIT_BITS = SUB_DIGIT_BITS
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] difference,
  output logic                borrow,
  output logic                overflow,
  output sub_state_t          state_dbg
);

  // Handshake: start is accepted on a rising edge while in IDLE or DONE (ignored
  // in CALC); busy is high for the DIGITS compute cycles; done is a one-cycle
  // pulse and the new difference/borrow/overflow are already valid during it.

  localparam int DIGITS = NUM_BITS / DIGIT_BITS;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MSB    = NUM_BITS - 1;

  if (NUM_BITS % DIGIT_BITS != 0) begin : g_bad_width
    $error("NUM_BITS must be an exact multiple of DIGIT_BITS");
  end

  sub_state_t state, state_next;

  logic [NUM_BITS-1:0]            a_reg, b_reg, res_reg;
  logic                           carry, a_msb, b_msb;
  logic [CNT_W-1:0]               cnt;
  logic [DIGIT_BITS-1:0]          digit_sum;
  logic                           digit_cout;
  logic [NUM_BITS+DIGIT_BITS-1:0] res_cat;
  logic [NUM_BITS-1:0]            res_next;
  logic                           accept, last_digit;

  assign accept     = start && (state == IDLE || state == DONE);
  assign last_digit = (cnt == CNT_W'(DIGITS - 1));

  adder_nbit #(.N(DIGIT_BITS)) u_digit_adder (
    .a         (a_reg[DIGIT_BITS-1:0]),
    .b         (b_reg[DIGIT_BITS-1:0]),
    .carry_in  (carry),
    .sum       (digit_sum),
    .carry_out (digit_cout)
  );

  // New digit enters at the MSB end so the LSB digit lands at the bottom after DIGITS shifts.
  assign res_cat  = {digit_sum, res_reg};
  assign res_next = res_cat[NUM_BITS+DIGIT_BITS-1:DIGIT_BITS];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_digit) state_next = DONE;
      DONE:    state_next = start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == CALC);
    done      = (state == DONE);
    state_dbg = state;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      difference <= '0;
      borrow     <= 1'b0;
      overflow   <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= ~b;
      carry <= 1'b1;
      cnt   <= '0;
      a_msb <= a[MSB];
      b_msb <= b[MSB];
    end else if (state == CALC) begin
      a_reg   <= a_reg >> DIGIT_BITS;
      b_reg   <= b_reg >> DIGIT_BITS;
      res_reg <= res_next;
      carry   <= digit_cout;
      cnt     <= cnt + CNT_W'(1);
      if (last_digit) begin
        difference <= res_next;
        borrow     <= ~digit_cout;
        overflow   <= (a_msb != b_msb) && (res_next[MSB] != a_msb);
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (n_rst) begin
      assert (!$isunknown(start)) else $error("start is X/Z");
      if (accept) begin
        assert (!$isunknown({a, b})) else $error("operands are X/Z at start");
      end
    end
  end
`endif

endmodule
